// File: rtl/n64_pi_initiator_if.sv
// n64_pi_initiator_if: command port and PI cartridge-bus signals of the PI initiator
interface n64_pi_initiator_if;
   logic        i_request;
   logic        i_write;
   logic [31:0] i_address;
   logic [7:0]  i_length;
   logic        o_busy;
   logic        o_done;
   logic [15:0] i_wdata;
   logic        o_wdata_pop;
   logic [15:0] o_rdata;
   logic        o_rdata_valid;
   logic        o_pi_aleh;
   logic        o_pi_alel;
   logic        o_pi_read_n;
   logic        o_pi_write_n;
   logic [15:0] o_pi_ad;
   logic        o_pi_ad_oe;
   logic [15:0] i_pi_ad;
   modport master (
      input  i_request, i_write, i_address, i_length, i_wdata, i_pi_ad,
      output o_busy, o_done, o_wdata_pop, o_rdata, o_rdata_valid,
             o_pi_aleh, o_pi_alel, o_pi_read_n, o_pi_write_n, o_pi_ad, o_pi_ad_oe
   );
   modport slave (
      output i_request, i_write, i_address, i_length, i_wdata, i_pi_ad,
      input  o_busy, o_done, o_wdata_pop, o_rdata, o_rdata_valid,
             o_pi_aleh, o_pi_alel, o_pi_read_n, o_pi_write_n, o_pi_ad, o_pi_ad_oe
   );
endinterface

// File: rtl/n64_pi_initiator.sv
// n64_pi_initiator: PI bus master running ALEH/ALEL address latching then strobed word bursts
module n64_pi_initiator #(
   parameter int T_ALE     = 4,
   parameter int T_PULSE   = 6,
   parameter int T_RELEASE = 2
) (
   input logic               i_clk,
   input logic               i_reset,
   n64_pi_initiator_if.master bus
);
   localparam int T_MAX = (T_ALE > T_PULSE) ? ((T_ALE > T_RELEASE) ? T_ALE : T_RELEASE)
                                            : ((T_PULSE > T_RELEASE) ? T_PULSE : T_RELEASE);
   localparam int CW    = ($clog2(T_MAX) > 0) ? $clog2(T_MAX) : 1;
   typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, GAP, STROBE, RELEASE} state_t;
   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [7:0]    words, words_n;
   logic          wr, wr_n;
   logic [31:0]   addr, addr_n;
   logic          last;
   logic          pop_n, valid_n, done_n;
   logic [15:0]   ad_n;
   // next state, phase/word counters and the next value of every registered output
   always_comb begin
      last    = (cnt == '0);
      state_n = state;
      wr_n    = wr;
      addr_n  = addr;
      words_n = words;
      case (state)
         IDLE:    if (bus.i_request) begin
                     state_n = ADDR_H;
                     wr_n    = bus.i_write;
                     addr_n  = bus.i_address;
                     words_n = bus.i_length;
                  end
         ADDR_H:  if (last) state_n = ADDR_L;
         ADDR_L:  if (last) state_n = GAP;
         GAP:     if (last) state_n = STROBE;
         STROBE:  if (last) state_n = RELEASE;
         RELEASE: if (last) begin
                     state_n = (words == 8'd0) ? IDLE : STROBE;
                     words_n = (words == 8'd0) ? words : words - 8'd1;
                  end
         default: state_n = IDLE;
      endcase
      cnt_n   = (state_n != state) ? ((state_n == STROBE)  ? CW'(T_PULSE - 1) :
                                      (state_n == RELEASE) ? CW'(T_RELEASE - 1) : CW'(T_ALE - 1))
                                   : cnt - CW'(1);
      pop_n   = wr_n && (cnt_n == '0) && (state_n == GAP || (state_n == RELEASE && words_n != 8'd0));
      valid_n = !wr && state == STROBE && last;
      done_n  = state == RELEASE && last && words == 8'd0;
      ad_n    = (state_n == ADDR_H) ? addr_n[31:16] :
                (state_n == ADDR_L || (state_n == GAP && wr_n)) ? (addr_n[15:0] & 16'hFFFE) :
                ((state_n == STROBE || state_n == RELEASE) && wr_n) ? (bus.o_wdata_pop ? bus.i_wdata : bus.o_pi_ad) :
                16'h0000;
   end
   // state register and registered bus/command outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state             <= IDLE;
         cnt               <= '0;
         words             <= 8'd0;
         wr                <= 1'b0;
         addr              <= 32'd0;
         bus.o_busy        <= 1'b0;
         bus.o_done        <= 1'b0;
         bus.o_wdata_pop   <= 1'b0;
         bus.o_rdata       <= 16'h0000;
         bus.o_rdata_valid <= 1'b0;
         bus.o_pi_aleh     <= 1'b0;
         bus.o_pi_alel     <= 1'b0;
         bus.o_pi_read_n   <= 1'b1;
         bus.o_pi_write_n  <= 1'b1;
         bus.o_pi_ad       <= 16'h0000;
         bus.o_pi_ad_oe    <= 1'b0;
      end else begin
         state             <= state_n;
         cnt               <= cnt_n;
         words             <= words_n;
         wr                <= wr_n;
         addr              <= addr_n;
         bus.o_busy        <= state_n != IDLE;
         bus.o_done        <= done_n;
         bus.o_wdata_pop   <= pop_n;
         bus.o_rdata       <= valid_n ? bus.i_pi_ad : bus.o_rdata;
         bus.o_rdata_valid <= valid_n;
         bus.o_pi_aleh     <= state_n == ADDR_H;
         bus.o_pi_alel     <= state_n == ADDR_H || state_n == ADDR_L;
         bus.o_pi_read_n   <= !(state_n == STROBE && !wr_n);
         bus.o_pi_write_n  <= !(state_n == STROBE && wr_n);
         bus.o_pi_ad       <= ad_n;
         bus.o_pi_ad_oe    <= state_n == ADDR_H || state_n == ADDR_L ||
                              (wr_n && (state_n == GAP || state_n == STROBE || state_n == RELEASE));
      end
   end
endmodule

// File: tb/tb_n64_pi_initiator.sv
// tb_n64_pi_initiator: directed scoreboard bench for the PI initiator with a simple responder model
module tb_n64_pi_initiator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   n64_pi_initiator_if b0 ();
   n64_pi_initiator_if b1 ();
   n64_pi_initiator u0 (.i_clk(clk), .i_reset(rst), .bus(b0));
   n64_pi_initiator #(.T_ALE(1), .T_PULSE(1), .T_RELEASE(1)) u1 (.i_clk(clk), .i_reset(rst), .bus(b1));
   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] wsrc[$], wexp[$], rsrc[$], rexp[$], rsrc1[$], rexp1[$];
   int busy_c, pop_c, val_c, done_c, wlow_c, wfall_c, rlow_c;
   int busy1_c, rlow1_c, val1_c, done1_c;
   logic wr_prev = 1'b1, rd_prev = 1'b1, rd1_prev = 1'b1, adv = 1'b0;
   logic [15:0] cur_w;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_ctl"}, {b0.o_busy, b0.o_done, b0.o_wdata_pop, b0.o_rdata_valid, b0.o_pi_aleh,
                            b0.o_pi_alel, b0.o_pi_read_n, b0.o_pi_write_n, b0.o_pi_ad_oe}, 32'b000000110);
      check({tag, "_ad"}, b0.o_pi_ad, 32'h0);
      check({tag, "_rdata"}, b0.o_rdata, 32'h0);
   endtask
   task automatic clear_counts();
      busy_c = 0; pop_c = 0; val_c = 0; done_c = 0; wlow_c = 0; wfall_c = 0; rlow_c = 0;
      busy1_c = 0; rlow1_c = 0; val1_c = 0; done1_c = 0;
   endtask
   task automatic start(input logic w, input logic [31:0] a, input logic [7:0] l);
      @(posedge clk);
      clear_counts();
      @(negedge clk);
      b0.i_request = 1'b1;
      b0.i_write   = w;
      b0.i_address = a;
      b0.i_length  = l;
      @(negedge clk);
      b0.i_request = 1'b0;
   endtask
   task automatic wait_done(input int lim, input string tag);
      int k = 0;
      while (b0.o_done !== 1'b1 && k < lim) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_done_seen"}, k < lim, 1);
   endtask
   // monitor/responder for the default-timing instance: write data source, scoreboards, counters
   always @(negedge clk) begin
      if (adv && wsrc.size() > 0) wsrc.delete(0);
      adv = 1'b0;
      b0.i_wdata = (wsrc.size() > 0) ? wsrc[0] : 16'h0000;
      if (b0.o_wdata_pop) begin pop_c++; adv = 1'b1; end
      if (b0.o_busy) busy_c++;
      if (b0.o_done) done_c++;
      if (!b0.o_pi_write_n) begin
         wlow_c++;
         if (wr_prev) begin
            wfall_c++;
            check("wexp_avail", wexp.size() > 0, 1);
            cur_w = (wexp.size() > 0) ? wexp.pop_front() : 16'hxxxx;
         end
         check("wdata", b0.o_pi_ad, cur_w);
         check("wr_oe", b0.o_pi_ad_oe, 1);
      end
      wr_prev = b0.o_pi_write_n;
      if (b0.o_rdata_valid) begin
         val_c++;
         check("rexp_avail", rexp.size() > 0, 1);
         if (rexp.size() > 0) check("rdata", b0.o_rdata, rexp.pop_front());
      end
      if (!rd_prev && b0.o_pi_read_n && rsrc.size() > 0) rsrc.delete(0);
      if (!b0.o_pi_read_n) begin
         rlow_c++;
         check("rd_oe", b0.o_pi_ad_oe, 0);
      end
      b0.i_pi_ad = (!b0.o_pi_read_n && rsrc.size() > 0) ? rsrc[0] : 16'h0000;
      rd_prev = b0.o_pi_read_n;
   end
   // monitor/responder for the single-cycle-timing instance
   always @(negedge clk) begin
      if (b1.o_busy) busy1_c++;
      if (b1.o_done) done1_c++;
      if (!b1.o_pi_read_n) rlow1_c++;
      if (b1.o_rdata_valid) begin
         val1_c++;
         check("rexp1_avail", rexp1.size() > 0, 1);
         if (rexp1.size() > 0) check("rdata1", b1.o_rdata, rexp1.pop_front());
      end
      if (!rd1_prev && b1.o_pi_read_n && rsrc1.size() > 0) rsrc1.delete(0);
      b1.i_pi_ad = (!b1.o_pi_read_n && rsrc1.size() > 0) ? rsrc1[0] : 16'h0000;
      rd1_prev = b1.o_pi_read_n;
   end
   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
   initial begin
      clear_counts();
      b0.i_request = 1'b0; b0.i_write = 1'b0; b0.i_address = 32'h0; b0.i_length = 8'h0;
      b1.i_request = 1'b0; b1.i_write = 1'b0; b1.i_address = 32'h0; b1.i_length = 8'h0;
      b1.i_wdata = 16'h0000;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check("reset1_ctl", {b1.o_busy, b1.o_pi_read_n, b1.o_pi_write_n, b1.o_pi_ad_oe}, 32'b0110);
      rst = 1'b0;
      // single-word read, cycle-exact
      rsrc.push_back(16'hBEEF);
      rexp.push_back(16'hBEEF);
      start(1'b0, 32'h1000_0000, 8'd0);
      for (int c = 1; c <= 22; c++) begin
         if (c > 1) @(negedge clk);
         check("t1_aleh", b0.o_pi_aleh, c <= 4);
         check("t1_alel", b0.o_pi_alel, c <= 8);
         check("t1_oe", b0.o_pi_ad_oe, c <= 8);
         if (c <= 4) check("t1_ad_hi", b0.o_pi_ad, 32'h1000);
         else if (c <= 8) check("t1_ad_lo", b0.o_pi_ad, 32'h0000);
         check("t1_read_n", b0.o_pi_read_n, !(c >= 13 && c <= 18));
         check("t1_write_n", b0.o_pi_write_n, 1);
         check("t1_valid", b0.o_rdata_valid, c == 19);
         if (c == 19) check("t1_rdata", b0.o_rdata, 32'hBEEF);
         check("t1_done", b0.o_done, c == 21);
         check("t1_busy", b0.o_busy, c <= 20);
      end
      check("t1_busy_cycles", busy_c, 20);
      check("t1_valids", val_c, 1);
      check("t1_read_low", rlow_c, 6);
      // four-word write
      foreach (wsrc[i]) wsrc.delete(i);
      for (int i = 0; i < 4; i++) begin
         wsrc.push_back(16'h1111 * 16'(i + 1));
         wexp.push_back(16'h1111 * 16'(i + 1));
      end
      start(1'b1, 32'h1000_0041, 8'd3);
      check("t2_ad_hi", b0.o_pi_ad, 32'h1000);
      repeat (4) @(negedge clk);
      check("t2_ad_lo_bit0", b0.o_pi_ad, 32'h0040);
      wait_done(100, "t2");
      @(negedge clk);
      check("t2_pops", pop_c, 4);
      check("t2_strobes", wfall_c, 4);
      check("t2_write_low", wlow_c, 24);
      check("t2_busy_cycles", busy_c, 44);
      check("t2_dones", done_c, 1);
      check("t2_wexp_left", wexp.size(), 0);
      // 256-word read
      for (int i = 0; i < 256; i++) begin
         rsrc.push_back(16'(i * 37) ^ 16'h5A00);
         rexp.push_back(16'(i * 37) ^ 16'h5A00);
      end
      start(1'b0, 32'h1000_2000, 8'd255);
      wait_done(2200, "t3");
      @(negedge clk);
      check("t3_valids", val_c, 256);
      check("t3_busy_cycles", busy_c, 2060);
      check("t3_dones", done_c, 1);
      check("t3_read_low", rlow_c, 1536);
      check("t3_rexp_left", rexp.size(), 0);
      // request held high across a one-word read
      for (int i = 0; i < 2; i++) begin
         rsrc.push_back(16'hC0DE + 16'(i));
         rexp.push_back(16'hC0DE + 16'(i));
      end
      @(posedge clk);
      clear_counts();
      @(negedge clk);
      b0.i_request = 1'b1; b0.i_write = 1'b0; b0.i_address = 32'h1000_0100; b0.i_length = 8'd0;
      wait_done(40, "t4a");
      check("t4_busy_at_done", b0.o_busy, 0);
      check("t4_busy_first", busy_c, 20);
      @(negedge clk);
      check("t4_rebusy", b0.o_busy, 1);
      check("t4_reale", b0.o_pi_aleh, 1);
      b0.i_request = 1'b0;
      wait_done(40, "t4b");
      @(negedge clk);
      check("t4_busy_cycles", busy_c, 40);
      check("t4_dones", done_c, 2);
      check("t4_valids", val_c, 2);
      // reset during the second strobe of a four-word write
      for (int i = 0; i < 4; i++) begin
         wsrc.push_back(16'hA000 + 16'(i));
         wexp.push_back(16'hA000 + 16'(i));
      end
      start(1'b1, 32'h1000_0200, 8'd3);
      begin
         int k = 0;
         while (wfall_c < 2 && k < 100) begin
            @(negedge clk);
            k++;
         end
         check("t5_strobe2_seen", k < 100, 1);
      end
      rst = 1'b1;
      @(negedge clk);
      check_idle("t5_reset");
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("t5_pops", pop_c, 2);
      check("t5_dones", done_c, 0);
      check("t5_busy", b0.o_busy, 0);
      wsrc.delete();
      wexp.delete();
      // minimum timing, two-word read
      rsrc1.push_back(16'h1234);
      rexp1.push_back(16'h1234);
      rsrc1.push_back(16'hABCD);
      rexp1.push_back(16'hABCD);
      @(posedge clk);
      clear_counts();
      @(negedge clk);
      b1.i_request = 1'b1; b1.i_write = 1'b0; b1.i_address = 32'h0500_0000; b1.i_length = 8'd1;
      @(negedge clk);
      b1.i_request = 1'b0;
      begin
         int k = 0;
         while (b1.o_done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
         end
         check("t6_done_seen", k < 20, 1);
      end
      @(negedge clk);
      check("t6_busy_cycles", busy1_c, 7);
      check("t6_read_low", rlow1_c, 2);
      check("t6_valids", val1_c, 2);
      check("t6_dones", done1_c, 1);
      check("t6_rexp_left", rexp1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/n64_pi_initiator.md
# n64_pi_initiator

Parallel-interface (PI) bus initiator: drives the N64 cartridge-bus handshake (ALEH/ALEL address latching, then read/write strobes over a 16-bit multiplexed AD bus) from a simple command port. It is the counterpart of the cart-side responder and bank decoder. It serves as the bus master for self-test and loop-back fixtures and for the 64DD-side port, and it exercises the same address decoding the responder applies.

## Interface
Parameters:
- T_ALE, 4, cycles per address phase (ADDR_H, ADDR_L, GAP); ≥1
- T_PULSE, 6, cycles read_n/write_n held low per word; ≥1
- T_RELEASE, 2, cycles strobe held high between words; ≥1

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_request  in  1  start transaction; sampled only in IDLE
- i_write  in  1  1 = write burst, 0 = read burst; latched with request
- i_address  in  32  PI byte address; bit 0 ignored (forced 0 on bus)
- i_length  in  8  words in burst minus one (0 → 1 word, 255 → 256 words)
- o_busy  out  1  high from cycle after acceptance until back in IDLE
- o_done  out  1  one-cycle pulse on return to IDLE after a completed burst
- i_wdata  in  16  write word; must be valid in any cycle o_wdata_pop is high
- o_wdata_pop  out  1  one-cycle pulse, i_wdata consumed this cycle (show-ahead FIFO)
- o_rdata  out  16  captured read word
- o_rdata_valid  out  1  one-cycle pulse, o_rdata valid
- o_pi_aleh  out  1  ALE high strobe
- o_pi_alel  out  1  ALE low strobe
- o_pi_read_n  out  1  read strobe, active low
- o_pi_write_n  out  1  write strobe, active low
- o_pi_ad  out  16  AD bus output value
- o_pi_ad_oe  out  1  AD bus output enable
- i_pi_ad  in  16  AD bus input value

## Operation
- States: IDLE → ADDR_H → ADDR_L → GAP → STROBE ⇄ RELEASE → IDLE.
- IDLE: aleh=0, alel=0, read_n=1, write_n=1, ad_oe=0, ad=0. If i_request is high, latch write, address, and length, then go to ADDR_H.
- ADDR_H (T_ALE cycles): aleh=1, alel=1, ad=addr[31:16], oe=1.
- ADDR_L (T_ALE cycles): aleh=0, alel=1, ad={addr[15:1],1'b0}, oe=1.
- GAP (T_ALE cycles): aleh=0, alel=0. For writes, ad keeps the low address and oe=1. For reads, oe=0.
- STROBE (T_PULSE cycles): read_n or write_n = 0. For writes, ad = the popped word and oe=1. For reads, oe=0.
- RELEASE (T_RELEASE cycles): strobes =1; write data is still driven. If words remain, go to STROBE; otherwise go to IDLE.
- Writes: o_wdata_pop pulses in the last cycle of GAP and in the last cycle of every RELEASE that is followed by another STROBE. The word drives ad from the next cycle. Exactly length+1 pops per burst.
- Reads: i_pi_ad is captured in the last STROBE cycle. o_rdata_valid pulses in the first RELEASE cycle. Exactly length+1 pulses per burst.
- The responder auto-increments the address; the initiator never re-sends it.
- Word counter is 8 bits, loaded with i_length, and decremented at the end of each RELEASE. Exit when it reads 0 at the end of RELEASE; no wrap on 255.
- Phase counter is sized for max(T_ALE, T_PULSE, T_RELEASE). It reloads on every state entry.

## Timing
- Reset values: o_busy=0, o_done=0, o_wdata_pop=0, o_rdata_valid=0, o_rdata=0, aleh=0, alel=0, read_n=1, write_n=1, ad=0, ad_oe=0. State is IDLE.
- Request accepted in cycle 0 → ADDR_H outputs from cycle 1. The first strobe falls at cycle 1+3·T_ALE.
- Busy duration: 3·T_ALE + N·(T_PULSE+T_RELEASE) cycles, where N = length+1.
- o_done is high in the first IDLE cycle, with busy already 0. A request in that same cycle is accepted.
- i_request while busy: ignored, not queued.
- Reset mid-burst: all outputs return to reset values the next cycle. No o_done, and no further pop or valid pulses.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Read, length=0, addr 0x1000_0000, defaults: aleh=1 with ad=0x1000 for cycles 1–4; alel=1 with ad=0x0000 for cycles 5–8; read_n=0 for cycles 13–18. Responder drives 0xBEEF → one o_rdata_valid with 0xBEEF at cycle 19. o_done at cycle 21; busy for 20 cycles.
- Write, length=3, data 0x1111/0x2222/0x3333/0x4444: 4 pops, 4 write_n pulses each 6 cycles low with matching ad, busy 44 cycles.
- Read, length=255: exactly 256 o_rdata_valid pulses, busy 2060 cycles, a single o_done.
- i_request held high throughout a 1-word read: second transaction starts in the o_done cycle; no request is accepted while busy.
- i_reset asserted during the 2nd STROBE of a 4-word write: the next cycle shows reset outputs, no o_done, and 2 pops in total.
- Parameters T_ALE=1, T_PULSE=1, T_RELEASE=1, 2-word read: busy 7 cycles, read_n low for 1 cycle twice, data captured correctly.
